uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among N_REQ frame requesters.
// Define UART_ARB_TIMEOUT_EN to force release of a grant left idle for TIMEOUT_CLK cycles.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CLK = 50_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     req_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_req,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CLK < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CLK at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SEND,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  int unsigned      scan_idx;
  logic             req_g;
  logic             vld_g;
  logic             vld_eff;
  logic [7:0]       data_g;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;
  logic [CNT_W-1:0] cnt;
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search starting just after the last released grant.
  always_comb begin
    win_idx  = '0;
    win_vld  = 1'b0;
    scan_idx = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = (32'(last_grant) + 32'd1 + i) % N_REQ;
      if (!win_vld && req[IDX_W'(scan_idx)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(scan_idx);
      end
    end
  end

  // While req_ack is showing, the requester has not yet had a chance to drop
  // req_vld, so the level it presents this cycle still belongs to the old byte.
  always_comb begin
    req_g   = req[gidx];
    vld_g   = req_vld[gidx];
    data_g  = req_data[{gidx, 3'b000} +: 8];
    vld_eff = vld_g & ~(|req_ack);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      gidx       <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      req_ack    <= '0;
      tx_req     <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout    <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      req_ack <= '0;
      tx_req  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_vld) begin
            state <= GRANT;
            gnt   <= N_REQ'(1) << win_idx;
            gidx  <= win_idx;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (vld_eff) begin
            state   <= SEND;
            tx_data <= data_g;
            tx_req  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
          end else if (!req_g) begin
            state <= RELEASE;
            gnt   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CLK - 1)) begin
            state   <= RELEASE;
            gnt     <= '0;
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        SEND: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state   <= GRANT;
            req_ack <= gnt;
          end
        end
        RELEASE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          last_grant <= gidx;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the bench plays the requesters and the uart_tx.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned TIMEOUT_CLK = 16;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [N_REQ-1:0]     req_vld = '0;
  logic [8*N_REQ-1:0]   req_data = '0;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     req_ack;
  logic [7:0]           tx_data;
  logic                 tx_req;
  logic                 tx_done = 1'b0;
  logic                 busy;
  logic                 timeout;

  int checks = 0;
  int failures = 0;
  int n_txreq = 0;

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .TIMEOUT_CLK (TIMEOUT_CLK)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .req_vld   (req_vld),
    .req_data  (req_data),
    .gnt       (gnt),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .tx_done   (tx_done),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (tx_req) n_txreq <= n_txreq + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_dut();
    sys_rst_n = 1'b0;
    req       = '0;
    req_vld   = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask

  // One byte from requester idx: wait for its tx_req, hold uart busy, then tx_done.
  task automatic xfer(input int idx, input logic [7:0] d);
    logic got;
    req_vld[idx]         = 1'b1;
    req_data[8*idx +: 8] = d;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      got = tx_req;
    end
    check("tx_req_seen", 32'(got), 32'd1);
    check("gnt_owner", 32'(gnt), 32'd1 << idx);
    check("tx_data", 32'(tx_data), 32'(d));
    repeat (3) step();
    check("wait_quiet", 32'(req_ack) | 32'(tx_req), 32'd0);
    check("tx_data_hold", 32'(tx_data), 32'(d));
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("req_ack", 32'(req_ack), 32'd1 << idx);
  endtask

  initial begin
    int  base;
    logic seen;
    int  order2 [2];
    order2[0] = 0;
    order2[1] = 2;

    // Reset values
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    sys_rst_n = 1'b1;
    step();

    // Three bytes in one frame from requester 0
    base = n_txreq;
    req = 4'b0001;
    xfer(0, 8'h41);
    step();
    check("ack_cycle_vld_ignored", 32'(tx_req), 32'd0);
    xfer(0, 8'h42);
    xfer(0, 8'h43);
    req     = '0;
    req_vld = '0;
    step();
    check("rel_gnt", 32'(gnt), 32'd0);
    check("rel_busy", 32'(busy), 32'd1);
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("txreq_count", 32'(n_txreq - base), 32'd3);

    // Round-robin order 0,1,2,3 from reset, then 0,2
    reset_dut();
    req = 4'b1111;
    for (int w = 0; w < 4; w++) begin
      xfer(w, 8'(8'h10 + w));
      req[w]     = 1'b0;
      req_vld[w] = 1'b0;
      if (w == 3) begin
        req[0] = 1'b1;
        req[2] = 1'b1;
      end
      step();
      check("rr_gap1", 32'(gnt), 32'd0);
      step();
      check("rr_gap2", 32'(gnt) | 32'(busy), 32'd0);
    end
    for (int j = 0; j < 2; j++) begin
      xfer(order2[j], 8'(8'h20 + j));
      req[order2[j]]     = 1'b0;
      req_vld[order2[j]] = 1'b0;
      step();
      step();
    end

    // Byte offered in the same GRANT cycle as req falls
    req = 4'b0010;
    step();
    check("drop_gnt", 32'(gnt), 32'd2);
    req             = 4'b0000;
    req_vld[1]      = 1'b1;
    req_data[15:8]  = 8'h55;
    step();
    check("drop_tx_req", 32'(tx_req), 32'd1);
    check("drop_tx_data", 32'(tx_data), 32'h55);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("drop_ack", 32'(req_ack), 32'd2);
    req_vld = '0;
    step();
    check("drop_rel", 32'(gnt), 32'd0);
    step();
    check("drop_idle", 32'(busy), 32'd0);

    // Stray tx_done in IDLE and in GRANT
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("stray_idle", 32'(req_ack) | 32'(gnt) | 32'(busy), 32'd0);
    req = 4'b0001;
    step();
    check("stray_gnt", 32'(gnt), 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("stray_grant_ack", 32'(req_ack) | 32'(tx_req), 32'd0);
    check("stray_grant_hold", 32'(gnt), 32'd1);
    req = '0;
    step();
    step();

    // Reset while waiting for tx_done
    req          = 4'b0001;
    req_vld      = 4'b0001;
    req_data[7:0] = 8'h77;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      seen = tx_req;
    end
    check("abort_tx_req", 32'(seen), 32'd1);
    step();
    sys_rst_n = 1'b0;
    #1;
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    req     = '0;
    req_vld = '0;
    step();
    sys_rst_n = 1'b1;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("abort_no_ack", 32'(req_ack) | 32'(gnt) | 32'(busy), 32'd0);
    step();

    // Idle grant: forced release with timeout, or held forever without it
    req = 4'b1100;
    step();
    check("to_gnt2", 32'(gnt), 32'd4);
`ifdef UART_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (timeout) seen = 1'b1;
    end
    check("to_early", 32'(seen), 32'd0);
    step();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_gnt_clr", 32'(gnt), 32'd0);
    step();
    check("to_pulse_end", 32'(timeout), 32'd0);
    step();
    check("to_next_gnt", 32'(gnt), 32'd8);
`else
    seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (timeout || gnt != 4'b0100) seen = 1'b1;
    end
    check("hold_gnt", 32'(seen), 32'd0);
`endif
    req = '0;
    step();
    step();
    check("end_idle", 32'(busy) | 32'(gnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
